// File: rtl/sfu_coef_scheduler.sv
// Round-robin front end for the SFU coefficient ROM: arbitrates NREQ requesters,
// issues ROM lookups from stage A and captures coefficients in stage B.
module sfu_coef_scheduler #(
  parameter int NREQ      = 4,
  parameter int XW        = 23,
  parameter int ADDR_BITS = 7,
  parameter int FN_BITS   = 4,
  parameter int BUS_C0    = 29,
  parameter int BUS_C1    = 20,
  parameter int BUS_C2    = 14,
  parameter int IDW       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*FN_BITS-1:0] req_fn,
  input  logic [NREQ*XW-1:0]      req_x,
  output logic [ADDR_BITS-1:0]    rom_addr,
  output logic [FN_BITS-1:0]      rom_fn,
  input  logic [BUS_C0-1:0]       rom_c0,
  input  logic [BUS_C1-1:0]       rom_c1,
  input  logic [BUS_C2-1:0]       rom_c2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDW-1:0]          out_id,
  output logic [FN_BITS-1:0]      out_fn,
  output logic [BUS_C0-1:0]       out_c0,
  output logic [BUS_C1-1:0]       out_c1,
  output logic [BUS_C2-1:0]       out_c2,
  output logic [XW-ADDR_BITS:0]   out_xl,
  output logic                    out_seg64,
  output logic                    out_err
);

  localparam int XLW = XW - ADDR_BITS + 1;

  // Handshake: a transfer happens on a clock edge where valid and ready are both 1;
  // ready never depends on the same-cycle valid of the stage it accepts into.

  function automatic logic [IDW-1:0] wrap_idx(input int v);
    return IDW'(v % NREQ);
  endfunction

  logic               a_valid_q, a_valid_d;
  logic [IDW-1:0]     a_id_q, a_id_d;
  logic [FN_BITS-1:0] a_fn_q, a_fn_d;
  logic [XW-1:0]      a_x_q, a_x_d;

  logic               b_valid_q, b_valid_d;
  logic [IDW-1:0]     b_id_q, b_id_d;
  logic [FN_BITS-1:0] b_fn_q, b_fn_d;
  logic [BUS_C0-1:0]  b_c0_q, b_c0_d;
  logic [BUS_C1-1:0]  b_c1_q, b_c1_d;
  logic [BUS_C2-1:0]  b_c2_q, b_c2_d;
  logic [XLW-1:0]     b_xl_q, b_xl_d;
  logic               b_seg64_q, b_seg64_d;
  logic               b_err_q, b_err_d;

  logic [IDW-1:0]     ptr_q, ptr_d;

  logic               adv_a, adv_b, any_req, accept, fn_err, fn_seg64;
  logic [IDW-1:0]     grant_idx;
  logic [FN_BITS-1:0] fn_arr [NREQ];
  logic [XW-1:0]      x_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      fn_arr[i] = req_fn[i*FN_BITS +: FN_BITS];
      x_arr[i]  = req_x[i*XW +: XW];
    end
  end

  // Scan downward so the requester closest to ptr (smallest offset) wins.
  always_comb begin
    grant_idx = ptr_q;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_valid[wrap_idx(int'(ptr_q) + off)]) grant_idx = wrap_idx(int'(ptr_q) + off);
    end
  end

  assign any_req = |req_valid;
  assign adv_b   = !b_valid_q || out_ready;
  assign adv_a   = !a_valid_q || adv_b;
  assign accept  = !rst && adv_a && any_req;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign rom_addr = a_valid_q ? a_x_q[XW-1 -: ADDR_BITS] : '0;
  assign rom_fn   = a_valid_q ? a_fn_q : '0;

  assign fn_err   = (a_fn_q >= FN_BITS'(10));
  assign fn_seg64 = (a_fn_q == FN_BITS'(0)) || (a_fn_q == FN_BITS'(1)) ||
                    (a_fn_q == FN_BITS'(5)) || (a_fn_q == FN_BITS'(6)) ||
                    (a_fn_q == FN_BITS'(8)) || (a_fn_q == FN_BITS'(9));

  always_comb begin
    ptr_d     = ptr_q;
    a_valid_d = a_valid_q;
    a_id_d    = a_id_q;
    a_fn_d    = a_fn_q;
    a_x_d     = a_x_q;
    if (accept) ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    if (adv_a) a_valid_d = any_req;
    if (accept) begin
      a_id_d = grant_idx;
      a_fn_d = fn_arr[grant_idx];
      a_x_d  = x_arr[grant_idx];
    end
  end

  // Bubbles only clear b_valid; the data regs keep the last delivered op.
  always_comb begin
    b_valid_d = b_valid_q;
    b_id_d    = b_id_q;
    b_fn_d    = b_fn_q;
    b_c0_d    = b_c0_q;
    b_c1_d    = b_c1_q;
    b_c2_d    = b_c2_q;
    b_xl_d    = b_xl_q;
    b_seg64_d = b_seg64_q;
    b_err_d   = b_err_q;
    if (adv_b) b_valid_d = a_valid_q;
    if (adv_b && a_valid_q) begin
      b_id_d    = a_id_q;
      b_fn_d    = a_fn_q;
      b_c0_d    = fn_err ? '0 : rom_c0;
      b_c1_d    = fn_err ? '0 : rom_c1;
      b_c2_d    = fn_err ? '0 : rom_c2;
      b_xl_d    = a_x_q[XLW-1:0];
      b_seg64_d = !fn_err && fn_seg64;
      b_err_d   = fn_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      a_valid_q <= 1'b0;
      a_id_q    <= '0;
      a_fn_q    <= '0;
      a_x_q     <= '0;
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
      b_fn_q    <= '0;
      b_c0_q    <= '0;
      b_c1_q    <= '0;
      b_c2_q    <= '0;
      b_xl_q    <= '0;
      b_seg64_q <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      a_valid_q <= a_valid_d;
      a_id_q    <= a_id_d;
      a_fn_q    <= a_fn_d;
      a_x_q     <= a_x_d;
      b_valid_q <= b_valid_d;
      b_id_q    <= b_id_d;
      b_fn_q    <= b_fn_d;
      b_c0_q    <= b_c0_d;
      b_c1_q    <= b_c1_d;
      b_c2_q    <= b_c2_d;
      b_xl_q    <= b_xl_d;
      b_seg64_q <= b_seg64_d;
      b_err_q   <= b_err_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_id    = b_id_q;
  assign out_fn    = b_fn_q;
  assign out_c0    = b_c0_q;
  assign out_c1    = b_c1_q;
  assign out_c2    = b_c2_q;
  assign out_xl    = b_xl_q;
  assign out_seg64 = b_seg64_q;
  assign out_err   = b_err_q;

endmodule

// File: tb/tb_sfu_coef_scheduler.sv
// Directed bench for sfu_coef_scheduler with a small synthetic coefficient ROM model.
module tb_sfu_coef_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_fn;
  logic [91:0] req_x;
  logic [6:0]  rom_addr;
  logic [3:0]  rom_fn;
  logic [28:0] rom_c0;
  logic [19:0] rom_c1;
  logic [13:0] rom_c2;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [3:0]  out_fn;
  logic [28:0] out_c0;
  logic [19:0] out_c1;
  logic [13:0] out_c2;
  logic [16:0] out_xl;
  logic        out_seg64;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  sfu_coef_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_fn(req_fn), .req_x(req_x), .rom_addr(rom_addr), .rom_fn(rom_fn),
    .rom_c0(rom_c0), .rom_c1(rom_c1), .rom_c2(rom_c2), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_fn(out_fn), .out_c0(out_c0),
    .out_c1(out_c1), .out_c2(out_c2), .out_xl(out_xl), .out_seg64(out_seg64),
    .out_err(out_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [28:0] rom_c0_f(input logic [3:0] fn, input logic [6:0] a);
    return {fn, a, a, 11'h5A5};
  endfunction
  function automatic logic [19:0] rom_c1_f(input logic [3:0] fn, input logic [6:0] a);
    return {a, ~fn, 9'h1C3};
  endfunction
  function automatic logic [13:0] rom_c2_f(input logic [3:0] fn, input logic [6:0] a);
    return {fn ^ 4'hA, a, 3'b101};
  endfunction

  always_comb begin
    rom_c0 = rom_c0_f(rom_fn, rom_addr);
    rom_c1 = rom_c1_f(rom_fn, rom_addr);
    rom_c2 = rom_c2_f(rom_fn, rom_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] fn, input logic [22:0] x);
    req_fn[i*4 +: 4]   = fn;
    req_x[i*23 +: 23]  = x;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    req_valid = 4'h0;
    out_ready = 1'b1;
    nxt();
    nxt();
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    nxt();
    rst = 1'b0;
    req_valid = 4'h0;
  endtask

  logic [22:0] xs [4];
  logic [16:0] held;
  logic [22:0] x3;
  int sent, received;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_fn = '0;
    req_x = '0;
    out_ready = 1'b1;
    xs[0] = 23'h012345; xs[1] = 23'h1ABCDE; xs[2] = 23'h2F0F0F; xs[3] = 23'h7C1357;

    do_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_rom_addr", 64'(rom_addr), 64'h0);
    chk("rst_rom_fn", 64'(rom_fn), 64'h0);
    chk("rst_out_c0", 64'(out_c0), 64'h0);
    chk("rst_out_id", 64'(out_id), 64'h0);
    chk("rst_out_err", 64'(out_err), 64'h0);

    // Single op
    nxt();
    req_valid = 4'b0100;
    set_req(2, 4'd7, 23'h5A0000);
    #1;
    chk("t1_req_ready", 64'(req_ready), 64'h4);
    nxt();
    req_valid = 4'h0;
    #1;
    chk("t1_rom_addr", 64'(rom_addr), 64'h5A);
    chk("t1_rom_fn", 64'(rom_fn), 64'h7);
    chk("t1_out_valid_early", 64'(out_valid), 64'h0);
    nxt();
    #1;
    chk("t1_out_valid", 64'(out_valid), 64'h1);
    chk("t1_out_id", 64'(out_id), 64'h2);
    chk("t1_out_fn", 64'(out_fn), 64'h7);
    chk("t1_out_c0", 64'(out_c0), 64'(rom_c0_f(4'd7, 7'h5A)));
    chk("t1_out_c1", 64'(out_c1), 64'(rom_c1_f(4'd7, 7'h5A)));
    chk("t1_out_c2", 64'(out_c2), 64'(rom_c2_f(4'd7, 7'h5A)));
    chk("t1_out_xl", 64'(out_xl), 64'h0);
    chk("t1_out_seg64", 64'(out_seg64), 64'h0);
    chk("t1_out_err", 64'(out_err), 64'h0);
    nxt();
    #1;
    chk("t1_out_valid_after", 64'(out_valid), 64'h0);

    // Fairness: all four requesters active, grants rotate 0,1,2,3
    do_reset();
    for (int j = 0; j < 10; j++) begin
      if (j > 0) nxt();
      req_valid = (j < 8) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), xs[i]);
      #1;
      if (j < 8) chk("t2_req_ready", 64'(req_ready), 64'(4'b0001 << (j % 4)));
      if (j >= 2) begin
        chk("t2_out_valid", 64'(out_valid), 64'h1);
        chk("t2_out_id", 64'(out_id), 64'((j - 2) % 4));
        chk("t2_out_xl", 64'(out_xl), 64'(xs[(j - 2) % 4][16:0]));
        chk("t2_out_c0", 64'(out_c0), 64'(rom_c0_f(4'((j - 2) % 4 + 1), xs[(j - 2) % 4][22:16])));
      end
    end
    req_valid = 4'h0;

    // Backpressure: stream from requester 1, out_ready low on cycles 3..5
    do_reset();
    sent = 0;
    received = 0;
    held = '0;
    for (int c = 0; c < 25 && (sent < 6 || received < 6); c++) begin
      if (c > 0) nxt();
      x3 = 23'h400000 + 23'(sent) * 23'h01357;
      req_valid = (sent < 6) ? 4'b0010 : 4'b0000;
      set_req(1, 4'd3, x3);
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        chk("t3_stall_ready", 64'(req_ready), 64'h0);
        chk("t3_stall_valid", 64'(out_valid), 64'h1);
        if (c == 3) held = out_xl;
        else chk("t3_stall_hold", 64'(out_xl), 64'(held));
      end
      if (out_valid && out_ready) begin
        chk("t3_out_expected", 64'(exp_q.size() != 0), 64'h1);
        if (exp_q.size() != 0) chk("t3_out_xl", 64'(out_xl), 64'(exp_q.pop_front()));
        received++;
      end
      if (req_ready[1]) begin
        exp_q.push_back(x3[16:0]);
        sent++;
      end
    end
    out_ready = 1'b1;
    req_valid = 4'h0;
    chk("t3_received", 64'(received), 64'd6);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Invalid fn
    nxt();
    req_valid = 4'b0001;
    set_req(0, 4'd12, 23'h123456);
    #1;
    chk("t4_req_ready", 64'(req_ready), 64'h1);
    nxt();
    req_valid = 4'h0;
    #1;
    chk("t4_rom_fn", 64'(rom_fn), 64'd12);
    chk("t4_rom_addr", 64'(rom_addr), 64'h12);
    nxt();
    #1;
    chk("t4_out_valid", 64'(out_valid), 64'h1);
    chk("t4_out_err", 64'(out_err), 64'h1);
    chk("t4_out_c0", 64'(out_c0), 64'h0);
    chk("t4_out_c1", 64'(out_c1), 64'h0);
    chk("t4_out_c2", 64'(out_c2), 64'h0);
    chk("t4_out_fn", 64'(out_fn), 64'd12);
    chk("t4_out_seg64", 64'(out_seg64), 64'h0);

    // 64-segment table at the top of the operand range
    nxt();
    req_valid = 4'b1000;
    set_req(3, 4'd0, 23'h7FFFFF);
    #1;
    chk("t5_req_ready", 64'(req_ready), 64'h8);
    nxt();
    req_valid = 4'h0;
    #1;
    chk("t5_rom_addr", 64'(rom_addr), 64'h7F);
    nxt();
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'h1);
    chk("t5_out_id", 64'(out_id), 64'h3);
    chk("t5_out_xl", 64'(out_xl), 64'h1FFFF);
    chk("t5_out_seg64", 64'(out_seg64), 64'h1);
    chk("t5_out_err", 64'(out_err), 64'h0);
    chk("t5_out_c0", 64'(out_c0), 64'(rom_c0_f(4'd0, 7'h7F)));

    // Reset mid-operation with both stages full; pointer would be 3 without reset
    nxt();
    req_valid = 4'b0010;
    set_req(1, 4'd2, 23'h111111);
    nxt();
    req_valid = 4'b0100;
    set_req(2, 4'd4, 23'h222222);
    nxt();
    req_valid = 4'h0;
    #1;
    chk("t6_pre_out_valid", 64'(out_valid), 64'h1);
    chk("t6_pre_rom_fn", 64'(rom_fn), 64'h4);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    req_valid = 4'b1001;
    set_req(0, 4'd1, 23'h0ABCDE);
    set_req(3, 4'd1, 23'h0FEDCB);
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'h0);
    chk("t6_rom_addr", 64'(rom_addr), 64'h0);
    chk("t6_rom_fn", 64'(rom_fn), 64'h0);
    chk("t6_req_ready", 64'(req_ready), 64'h1);
    nxt();
    req_valid = 4'h0;
    #1;
    chk("t6_no_stale", 64'(out_valid), 64'h0);
    nxt();
    #1;
    chk("t6_out_valid_new", 64'(out_valid), 64'h1);
    chk("t6_out_id_new", 64'(out_id), 64'h0);
    chk("t6_out_xl_new", 64'(out_xl), 64'h0BCDE);
    nxt();
    req_valid = 4'b1000;
    #1;
    chk("t6_req3_ready", 64'(req_ready), 64'h8);
    nxt();
    req_valid = 4'h0;
    nxt();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfu_coef_scheduler.md
Name: sfu_coef_scheduler

Overview:
- Round-robin scheduler that lets NREQ requesters share one SFU coefficient ROM (fn-selected C0/C1/C2 tables, combinational lookup).
- Arbitrates requests and drives the ROM `addr`/`fn` from registers.
- Captures the coefficients together with the interpolation operand low bits, and presents them with valid/ready to the quadratic interpolator datapath.
- Pipelined at 1 op/cycle, with full backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8)
- XW, 23, operand fraction width per request
- ADDR_BITS, 7, ROM address width (128-entry tables)
- FN_BITS, 4, function-select width
- BUS_C0, 29, C0 width
- BUS_C1, 20, C1 width
- BUS_C2, 14, C2 width
- IDW, 2, requester-id width (clog2(NREQ), min 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_fn  in  NREQ*FN_BITS  packed fn codes, requester i at [i*FN_BITS +: FN_BITS]
- req_x  in  NREQ*XW  packed operands, requester i at [i*XW +: XW]
- rom_addr  out  ADDR_BITS  ROM address
- rom_fn  out  FN_BITS  ROM function select
- rom_c0  in  BUS_C0  ROM C0
- rom_c1  in  BUS_C1  ROM C1
- rom_c2  in  BUS_C2  ROM C2
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_id  out  IDW  winning requester index
- out_fn  out  FN_BITS  fn of the result
- out_c0  out  BUS_C0  captured C0
- out_c1  out  BUS_C1  captured C1
- out_c2  out  BUS_C2  captured C2
- out_xl  out  XW-ADDR_BITS+1  interpolation operand, x[XW-ADDR_BITS:0]
- out_seg64  out  1  1 = 64-segment table (fn 0,1,5,6,8,9); downstream uses all of out_xl. 0 = 128-segment table; the MSB of out_xl is ignored.
- out_err  out  1  fn code out of range (>=10)

Behaviour:
- Reset:
  - All stage valids = 0; RR pointer = 0; req_ready = 0.
  - rom_addr = 0 and rom_fn = 0.
  - All out_* = 0 (out_valid = 0).
- Stage A (issue regs): a_valid, a_id, a_fn, a_x.
  - rom_addr = a_x[XW-1 -: ADDR_BITS] and rom_fn = a_fn when a_valid; both are 0 otherwise.
- Stage B (output regs): b_valid drives out_valid; the other B regs drive out_*.
- Flow control:
  - advB = !b_valid | out_ready.
  - advA = !a_valid | advB.
  - Stage B loads A when advB: b_valid <= a_valid.
  - Stage A loads the grant when advA: a_valid <= any(req_valid).
- Arbiter (combinational):
  - grant = first i with req_valid[i], searching from ptr upward, mod NREQ.
  - req_ready[grant] = advA & any(req_valid); all other req_ready bits = 0.
  - Accept = req_valid & req_ready.
- Pointer: on accept, ptr <= (grant+1) mod NREQ. With no accept, ptr holds.
- Latency and throughput:
  - Accept at edge k; out_valid is high after edge k+1 (2 cycles).
  - Throughput is 1/cycle while out_ready=1.
- Stall:
  - While out_valid & !out_ready, all out_* hold stable.
  - If a_valid is also set, stage A holds and rom_addr/rom_fn hold.
  - Any new request sees req_ready=0.
- Invalid fn (a_fn >= 10):
  - The op is still passed through. Stage B loads out_c0/c1/c2 = 0, out_err = 1, out_seg64 = 0.
- Valid fn: out_err = 0. out_seg64 = 1 iff fn ∈ {0,1,5,6,8,9}.
- Requester requirements: it keeps req_fn/req_x stable while req_valid=1 and not accepted. The scheduler does not check this.
- Reset mid-operation: in-flight ops are dropped with no output, and ptr returns to 0.
- NREQ=1: the arbiter degenerates to pass-through; ptr stays 0.

Test Plan:
1. Single op: after reset, req_valid[2]=1, fn=7, x=23'h5A0000, out_ready=1. The request is accepted in the first cycle (req_ready=4'b0100). rom_addr=7'h5A and rom_fn=7 in the next cycle. In the cycle after that, out_valid=1, out_id=2, out_c* = ROM values for fn7/addr 0x5A, out_xl=17'h00000, out_seg64=0, out_err=0.
2. Fairness: all 4 requesters hold req_valid=1 for 8 cycles, out_ready=1. Grant order is 0,1,2,3,0,1,2,3; out_valid is 1 on every cycle from the 3rd; out_id follows the same order.
3. Backpressure: stream ops from requester 1, and drop out_ready low for 3 cycles while out_valid=1. out_* stay frozen; req_ready=0 while stage A is occupied. After release, no op is lost or duplicated: the out_x sequence equals the input sequence.
4. Invalid fn: fn=12, x=any. The op completes after 2 cycles with out_err=1, out_c0=out_c1=out_c2=0, out_fn=12.
5. 64-segment table: fn=0, x=23'h7F_FFFF. rom_addr=7'h7F; out_xl=17'h1FFFF, out_seg64=1.
6. Reset mid-op: assert rst for 1 cycle while a_valid=b_valid=1. out_valid=0 on the next cycle and no stale result is emitted; the next request from requester 3 is granted before requester 0 only if requester 0 is idle (ptr=0).
